// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register writer.
package sccb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BITS  = 2'd2,
        ST_STOP  = 2'd3
    } sccb_state_e;

    localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'h42;
    localparam int unsigned QTR_CNT_W        = 8;
    localparam int unsigned BIT_CNT_W        = 5;
    localparam int unsigned BITS_PER_PHASE   = 9;
    localparam int unsigned BITS_PER_TXN     = 27;
    localparam int unsigned QTR_PER_TXN      = 113;

    // Which byte (0 = device address, 1 = register, 2 = data) a bit index belongs to.
    function automatic logic [1:0] phase_of(input logic [BIT_CNT_W-1:0] idx);
        if (idx < BIT_CNT_W'(BITS_PER_PHASE)) begin
            return 2'd0;
        end
        if (idx < BIT_CNT_W'(2 * BITS_PER_PHASE)) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    // Position of a bit inside its 9-bit phase; 8 is the don't-care (ACK) slot.
    function automatic logic [3:0] slot_of(input logic [BIT_CNT_W-1:0] idx);
        logic [BIT_CNT_W-1:0] s;
        case (phase_of(idx))
            2'd0:    s = idx;
            2'd1:    s = idx - BIT_CNT_W'(BITS_PER_PHASE);
            default: s = idx - BIT_CNT_W'(2 * BITS_PER_PHASE);
        endcase
        return 4'(s);
    endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-period time base: one-cycle tick every QTR_DIV clocks, restartable.
module sccb_qtr_tick
    import sccb_pkg::*;
#(
    parameter int unsigned QTR_DIV = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam logic [QTR_CNT_W-1:0] CNT_LAST = QTR_CNT_W'(QTR_DIV - 1);

    logic [QTR_CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_LAST);

    // Free-running divider; clr realigns the quarter boundary to the accept cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + QTR_CNT_W'(1);
        end
    end

endmodule

// File: rtl/sccb_reg_writer.sv
// SCCB 3-phase register write master (device address, register, data).
module sccb_reg_writer
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned QTR_DIV  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       sio_d_in,
    output logic       sio_c,
    output logic       sio_d_out,
    output logic       sio_d_oe,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_TXN - 1);

    sccb_state_e          state;
    logic [1:0]           qtr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           addr_q;
    logic [7:0]           data_q;

    logic                 tick_c;
    logic                 accept_c;
    logic [BIT_CNT_W-1:0] next_bit_c;
    logic [1:0]           next_drive_c;

    // {oe, value} for a bit slot: data bits MSB first, ACK slot released.
    function automatic logic [1:0] bit_drive(input logic [BIT_CNT_W-1:0] idx,
                                             input logic [7:0] a,
                                             input logic [7:0] d);
        logic [7:0] byte_v;
        logic [3:0] slot;
        case (phase_of(idx))
            2'd0:    byte_v = DEV_ADDR;
            2'd1:    byte_v = a;
            default: byte_v = d;
        endcase
        slot = slot_of(idx);
        if (slot == 4'd8) begin
            return 2'b01;
        end
        return {1'b1, byte_v[3'(4'd7 - slot)]};
    endfunction

    assign accept_c     = (state == ST_IDLE) && start;
    assign next_bit_c   = (state == ST_BITS) ? bit_cnt + BIT_CNT_W'(1) : '0;
    assign next_drive_c = bit_drive(next_bit_c, addr_q, data_q);

    sccb_qtr_tick #(
        .QTR_DIV (QTR_DIV)
    ) u_qtr_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept_c),
        .tick_c (tick_c)
    );

    // Transaction sequencer; every pin value is registered for the quarter it enters.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state     <= ST_IDLE;
            qtr       <= 2'd0;
            bit_cnt   <= '0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            sio_c     <= 1'b1;
            sio_d_out <= 1'b1;
            sio_d_oe  <= 1'b0;
            busy      <= 1'b0;
            nack      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q    <= reg_addr;
                        data_q    <= reg_data;
                        nack      <= 1'b0;
                        qtr       <= 2'd0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        sio_c     <= 1'b1;
                        sio_d_out <= 1'b1;
                        sio_d_oe  <= 1'b1;
                        state     <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick_c) begin
                        if (qtr == 2'd0) begin
                            qtr       <= 2'd1;
                            sio_d_out <= 1'b0;
                        end else begin
                            qtr                   <= 2'd0;
                            bit_cnt               <= '0;
                            sio_c                 <= 1'b0;
                            {sio_d_oe, sio_d_out} <= next_drive_c;
                            state                 <= ST_BITS;
                        end
                    end
                end

                ST_BITS: begin
                    if (tick_c) begin
                        case (qtr)
                            2'd0: begin
                                qtr   <= 2'd1;
                                sio_c <= 1'b1;
                            end
                            2'd1: begin
                                qtr <= 2'd2;
                            end
                            2'd2: begin
                                qtr   <= 2'd3;
                                sio_c <= 1'b0;
                                if ((slot_of(bit_cnt) == 4'd8) && sio_d_in) begin
                                    nack <= 1'b1;
                                end
                            end
                            default: begin
                                qtr <= 2'd0;
                                if (bit_cnt == LAST_BIT) begin
                                    sio_d_oe  <= 1'b1;
                                    sio_d_out <= 1'b0;
                                    state     <= ST_STOP;
                                end else begin
                                    bit_cnt               <= next_bit_c;
                                    {sio_d_oe, sio_d_out} <= next_drive_c;
                                end
                            end
                        endcase
                    end
                end

                ST_STOP: begin
                    if (tick_c) begin
                        case (qtr)
                            2'd0: begin
                                qtr   <= 2'd1;
                                sio_c <= 1'b1;
                            end
                            2'd1: begin
                                qtr       <= 2'd2;
                                sio_d_out <= 1'b1;
                            end
                            default: begin
                                qtr      <= 2'd0;
                                bit_cnt  <= '0;
                                sio_d_oe <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_reg_writer.sv
// Self-checking bench for sccb_reg_writer: scoreboarded SCCB decode plus protocol monitor.
module tb_sccb_reg_writer;

    localparam int unsigned Q   = 4;
    localparam int          TXN = 1 + 113 * Q;
    localparam logic [7:0]  DEV = 8'h42;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       sio_d_in;
    logic       sio_c;
    logic       sio_d_out;
    logic       sio_d_oe;
    logic       busy;
    logic       done;
    logic       nack;

    sccb_reg_writer #(
        .DEV_ADDR (DEV),
        .QTR_DIV  (Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .sio_d_in  (sio_d_in),
        .sio_c     (sio_c),
        .sio_d_out (sio_d_out),
        .sio_d_oe  (sio_d_oe),
        .busy      (busy),
        .done      (done),
        .nack      (nack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       nack;
        int         done_cyc;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         sel;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Slave model: ACK slot n (1..3) answers high when nack_sel == n, else low.
    int ack_idx  = 0;
    int nack_sel = 0;
    assign sio_d_in = (busy && !sio_d_oe) ? ((nack_sel != 0) && (ack_idx == nack_sel)) : 1'b1;

    logic line;
    assign line = sio_d_oe ? sio_d_out : sio_d_in;

    // Decoder: one sample per SIO_C rise; 27 bits plus the rise inside STOP gives 28.
    logic dec [0:31];
    int   dec_n     = 0;
    int   start_cnt = 0;
    int   stop_cnt  = 0;
    logic prev_c = 1'b1, prev_line = 1'b1, prev_busy = 1'b0, prev_oe = 1'b0;

    function automatic logic [7:0] dec_byte(input int base);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v = {v[6:0], dec[base + i]};
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            dec_n = 0; start_cnt = 0; stop_cnt = 0; ack_idx = 0;
        end else begin
            if (prev_busy && busy && prev_c && sio_c && (prev_line != line)) begin
                if (prev_line && !line) start_cnt++;
                else stop_cnt++;
            end
            if (busy && !prev_c && sio_c) begin
                if (dec_n < 32) dec[dec_n] = line;
                dec_n++;
            end
            if (busy && prev_oe && !sio_d_oe) ack_idx++;
            if (!busy) ack_idx = 0;
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_at_done", busy, 0);
                    check("rise_count", dec_n, 28);
                    check("byte_dev", dec_byte(0), e.b0);
                    check("byte_reg", dec_byte(9), e.b1);
                    check("byte_data", dec_byte(18), e.b2);
                    check("nack_at_done", nack, e.nack);
                    check("start_stop_conds", {start_cnt[15:0], stop_cnt[15:0]}, 32'h0001_0001);
                end
                dec_n = 0; start_cnt = 0; stop_cnt = 0;
            end
        end
        prev_c = sio_c; prev_line = line; prev_busy = busy; prev_oe = sio_d_oe;
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] d, input int sel, input int t);
        exp_t e;
        e.b0 = DEV; e.b1 = a; e.b2 = d; e.nack = (sel != 0); e.done_cyc = t;
        sb.push_back(e);
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] d, input int sel, output int t);
        @(posedge clk); #1;
        reg_addr = a; reg_data = d; nack_sel = sel; start = 1'b1; t = cyc;
        push_exp(a, d, sel, t + TXN);
        @(posedge clk); #1;
        start = 1'b0; reg_addr = 8'($urandom); reg_data = 8'($urandom);
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        check("nack_cleared_on_accept", nack, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); n++;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(posedge clk);
        #1;
    endtask

    vec_t vt [5];

    initial begin
        int t, snap;
        vt[0] = '{8'h12, 8'h80, 0};
        vt[1] = '{8'h12, 8'h80, 2};
        vt[2] = '{8'h00, 8'hFF, 0};
        vt[3] = '{8'hFF, 8'h00, 3};
        vt[4] = '{8'hA5, 8'h5A, 1};

        // Reset with start held: reset must win.
        rst = 1'b1; start = 1'b1; reg_addr = 8'hAA; reg_data = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sio_c", sio_c, 1);
        check("rst_sio_d_out", sio_d_out, 1);
        check("rst_sio_d_oe", sio_d_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;

        // Table-driven transactions.
        for (int i = 0; i < 5; i++) begin
            start_txn(vt[i].addr, vt[i].data, vt[i].sel, t);
            drain(TXN + 20);
            repeat (3) @(negedge clk);
            check("nack_holds_after_done", nack, (vt[i].sel != 0));
        end

        // Second start mid-transaction is ignored.
        start_txn(8'h12, 8'h80, 0, t);
        wait_cyc(t + 100);
        start = 1'b1; reg_addr = 8'h99; reg_data = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        drain(TXN + 20);
        snap = done_cnt;
        repeat (TXN) @(negedge clk);
        check("single_done", done_cnt - snap, 0);

        // Start held high: accepted again in the done cycle with new operands.
        @(posedge clk); #1;
        reg_addr = 8'h12; reg_data = 8'h80; nack_sel = 0; start = 1'b1; t = cyc;
        push_exp(8'h12, 8'h80, 0, t + TXN);
        push_exp(8'h3A, 8'hC5, 0, t + 2 * TXN);
        @(posedge clk); #1;
        reg_addr = 8'h3A; reg_data = 8'hC5;
        wait_cyc(t + TXN + 1);
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_start_q0", {sio_c, sio_d_oe, sio_d_out}, 3'b111);
        @(posedge clk); #1;
        start = 1'b0;
        drain(2 * TXN + 20);

        // Reset mid-transaction abandons it silently.
        start_txn(8'h12, 8'h80, 0, t);
        wait_cyc(t + 200);
        rst = 1'b1;
        sb.delete();
        snap = done_cnt;
        @(negedge clk);
        @(negedge clk);
        check("midrst_sio_c", sio_c, 1);
        check("midrst_sio_d_oe", sio_d_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (TXN + 20) @(negedge clk);
        check("midrst_no_done", done_cnt - snap, 0);

        start_txn(8'h6B, 8'h0A, 0, t);
        drain(TXN + 20);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
